// File: rtl/subtractor_serial_if.sv
// Handshake and operand/result bundle for subtractor_serial.
// master drives the request side; slave is the subtractor.
interface subtractor_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             borrow;
  logic             overflow;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, s, borrow, overflow
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, s, borrow, overflow
  );
endinterface

// File: rtl/subtractor_serial.sv
// Serial subtractor: computes a - b over WIDTH/CHUNK clocks, CHUNK bits per clock,
// LSB slice first, with unsigned borrow and optional signed overflow detection.
module subtractor_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input logic                clk,
  input logic                rst,
  subtractor_serial_if.slave bus
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
  logic             sm_q, a_msb_q, b_msb_q, brw_q;
  logic [CW-1:0]    cnt_q;
  logic [CHUNK:0]   slice;

  logic [WIDTH-1:0] s_q;
  logic             borrow_q, overflow_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        accept    = bus.start;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right each RUN cycle; the difference slice enters acc from the top,
  // so after N slices acc holds the full result aligned at bit 0.
  always_comb begin
    slice   = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, brw_q};
    acc_nxt = (acc_q >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
    last    = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      sm_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      brw_q      <= 1'b0;
      cnt_q      <= '0;
      s_q        <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      sm_q    <= bus.signed_mode;
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
      acc_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> CHUNK;
      b_q   <= b_q >> CHUNK;
      acc_q <= acc_nxt;
      brw_q <= slice[CHUNK];
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        s_q        <= acc_nxt;
        borrow_q   <= slice[CHUNK];
        overflow_q <= sm_q & (a_msb_q != b_msb_q) & (acc_nxt[WIDTH-1] != a_msb_q);
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.s        = s_q;
  assign bus.borrow   = borrow_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed bench for subtractor_serial across (WIDTH,CHUNK) = (8,1), (8,4), (8,8), (16,8).
// Expected results are hand-computed constants.
module tb_subtractor_serial;

  logic clk = 1'b0;
  logic rst;
  int   nchecks = 0;
  int   nerrors = 0;

  always #5 clk = ~clk;

  subtractor_serial_if #(.WIDTH(8))  if_a ();
  subtractor_serial_if #(.WIDTH(8))  if_b ();
  subtractor_serial_if #(.WIDTH(8))  if_c ();
  subtractor_serial_if #(.WIDTH(16)) if_d ();

  subtractor_serial #(.WIDTH(8),  .CHUNK(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  subtractor_serial #(.WIDTH(8),  .CHUNK(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  subtractor_serial #(.WIDTH(8),  .CHUNK(8)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
  subtractor_serial #(.WIDTH(16), .CHUNK(8)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [15:0] av,
                       input logic [15:0] bv, input logic sm);
    case (sel)
      0: begin if_a.start = st; if_a.a = av[7:0]; if_a.b = bv[7:0]; if_a.signed_mode = sm; end
      1: begin if_b.start = st; if_b.a = av[7:0]; if_b.b = bv[7:0]; if_b.signed_mode = sm; end
      2: begin if_c.start = st; if_c.a = av[7:0]; if_c.b = bv[7:0]; if_c.signed_mode = sm; end
      default: begin if_d.start = st; if_d.a = av; if_d.b = bv; if_d.signed_mode = sm; end
    endcase
  endtask

  task automatic sample(input int sel, output logic bsy, output logic dn,
                        output logic [15:0] sv, output logic br, output logic ov);
    case (sel)
      0: begin bsy = if_a.busy; dn = if_a.done; sv = 16'(if_a.s); br = if_a.borrow; ov = if_a.overflow; end
      1: begin bsy = if_b.busy; dn = if_b.done; sv = 16'(if_b.s); br = if_b.borrow; ov = if_b.overflow; end
      2: begin bsy = if_c.busy; dn = if_c.done; sv = 16'(if_c.s); br = if_c.borrow; ov = if_c.overflow; end
      default: begin bsy = if_d.busy; dn = if_d.done; sv = if_d.s; br = if_d.borrow; ov = if_d.overflow; end
    endcase
  endtask

  // One full operation: accept, n RUN cycles with operands scrambled, a one-cycle done pulse.
  task automatic run_op(input string tag, input int sel, input int n,
                        input logic [15:0] av, input logic [15:0] bv, input logic sm,
                        input logic [15:0] es, input logic eb, input logic eo);
    logic bsy, dn, br, ov;
    logic [15:0] sv;
    int run_cycles = 0;
    drive(sel, 1'b1, av, bv, sm);
    tick();
    drive(sel, 1'b0, ~av, ~bv, ~sm);
    for (int i = 0; i < n; i++) begin
      sample(sel, bsy, dn, sv, br, ov);
      if (bsy === 1'b1 && dn === 1'b0) run_cycles++;
      tick();
    end
    check({tag, " run_cycles"}, 16'(run_cycles), 16'(n));
    sample(sel, bsy, dn, sv, br, ov);
    check({tag, " done"}, {15'd0, dn}, 16'd1);
    check({tag, " busy_at_done"}, {15'd0, bsy}, 16'd0);
    check({tag, " s"}, sv, es);
    check({tag, " borrow"}, {15'd0, br}, {15'd0, eb});
    check({tag, " overflow"}, {15'd0, ov}, {15'd0, eo});
    tick();
    sample(sel, bsy, dn, sv, br, ov);
    check({tag, " done_pulse_end"}, {14'd0, bsy, dn}, 16'd0);
    check({tag, " s_hold"}, sv, es);
  endtask

  initial begin
    logic bsy, dn, br, ov;
    logic [15:0] sv;
    int stray;

    rst = 1'b1;
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 16'd0, 16'd0, 1'b0);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      sample(k, bsy, dn, sv, br, ov);
      check($sformatf("reset%0d", k), {sv[12:0], bsy, dn, br | ov}, 16'd0);
    end

    // rst held high with start asserted keeps everything idle
    drive(0, 1'b1, 16'd200, 16'd55, 1'b0);
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      sample(0, bsy, dn, sv, br, ov);
      if (bsy !== 1'b0 || dn !== 1'b0 || sv !== 16'd0) stray++;
    end
    check("rst_held", 16'(stray), 16'd0);
    drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
    rst = 1'b0;
    tick();

    run_op("a_200_55",   0, 8, 16'd200,  16'd55,   1'b0, 16'd145,  1'b0, 1'b0);
    run_op("a_5_10",     0, 8, 16'd5,    16'd10,   1'b0, 16'd251,  1'b1, 1'b0);
    run_op("a_s127_m1",  0, 8, 16'd127,  16'd255,  1'b1, 16'd128,  1'b1, 1'b1);
    run_op("a_eq",       0, 8, 16'h5A,   16'h5A,   1'b1, 16'h00,   1'b0, 1'b0);
    run_op("a_0_ff",     0, 8, 16'h00,   16'hFF,   1'b1, 16'h01,   1'b1, 1'b0);
    run_op("a_m128_1",   0, 8, 16'h80,   16'h01,   1'b1, 16'h7F,   1'b0, 1'b1);
    run_op("a_m128_1u",  0, 8, 16'h80,   16'h01,   1'b0, 16'h7F,   1'b0, 1'b0);
    run_op("b_3c_3c",    1, 2, 16'h3C,   16'h3C,   1'b0, 16'h00,   1'b0, 1'b0);
    run_op("b_10_01",    1, 2, 16'h10,   16'h01,   1'b0, 16'h0F,   1'b0, 1'b0);
    run_op("b_50_b0",    1, 2, 16'h50,   16'hB0,   1'b1, 16'hA0,   1'b1, 1'b1);
    run_op("c_33_44",    2, 1, 16'h33,   16'h44,   1'b0, 16'hEF,   1'b1, 1'b0);
    run_op("d_0_ffff",   3, 2, 16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0);
    run_op("d_8000_1",   3, 2, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    run_op("d_1234_234", 3, 2, 16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b0, 1'b0);

    // start held high, operands changing every cycle: back-to-back accepts on DONE only
    drive(0, 1'b1, 16'h10, 16'h01, 1'b0);
    tick();
    for (int op = 0; op < 2; op++) begin
      stray = 0;
      for (int i = 0; i < 8; i++) begin
        drive(0, 1'b1, 16'((i * 37 + op * 11) & 8'hFF), 16'((i * 91 + 3) & 8'hFF), i[0]);
        sample(0, bsy, dn, sv, br, ov);
        if (bsy !== 1'b1 || dn !== 1'b0) stray++;
        tick();
      end
      check($sformatf("b2b%0d busy", op), 16'(stray), 16'd0);
      sample(0, bsy, dn, sv, br, ov);
      check($sformatf("b2b%0d done", op), {14'd0, bsy, dn}, 16'd1);
      if (op == 0) begin
        check("b2b0 s", sv, 16'h0F);
        check("b2b0 borrow", {15'd0, br}, 16'd0);
        drive(0, 1'b1, 16'h20, 16'h30, 1'b0);
      end else begin
        check("b2b1 s", sv, 16'hF0);
        check("b2b1 borrow", {15'd0, br}, 16'd1);
        drive(0, 1'b0, 16'h00, 16'h00, 1'b0);
      end
      tick();
    end
    sample(0, bsy, dn, sv, br, ov);
    check("b2b idle", {14'd0, bsy, dn}, 16'd0);

    // reset on the 4th RUN cycle aborts without a done pulse
    drive(0, 1'b1, 16'd200, 16'd55, 1'b0);
    tick();
    drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample(0, bsy, dn, sv, br, ov);
    check("abort state", {14'd0, bsy, dn}, 16'd0);
    check("abort s", sv, 16'd0);
    check("abort flags", {14'd0, br, ov}, 16'd0);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      sample(0, bsy, dn, sv, br, ov);
      if (bsy !== 1'b0 || dn !== 1'b0) stray++;
    end
    check("abort no_done", 16'(stray), 16'd0);
    run_op("a_after_abort", 0, 8, 16'hFF, 16'h01, 1'b0, 16'hFE, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
